// File: rtl/pcgen_gshare_if.sv
// Frontend bus for pcgen_gshare: FTQ fetch-block output, backend redirect, resolved-branch update.
interface pcgen_gshare_if #(
   parameter int hlen = 8,
   parameter int idw  = 7
);
   logic            redir;
   logic [63:0]     redir_pc;
   logic [hlen-1:0] redir_ghist;
   logic            upd_valid;
   logic [63:0]     upd_pc;
   logic [63:0]     upd_target;
   logic            upd_taken;
   logic [1:0]      upd_kind;
   logic [hlen-1:0] upd_ghist;
   logic            out_ready;
   logic            out_valid;
   logic [idw-1:0]  out_id;
   logic [63:0]     out_pc;
   logic [7:0]      out_num;
   logic            out_taken;
   logic [63:0]     out_target;
   logic [hlen-1:0] out_ghist;

   modport master (
      input  redir, redir_pc, redir_ghist,
      input  upd_valid, upd_pc, upd_target, upd_taken, upd_kind, upd_ghist,
      input  out_ready,
      output out_valid, out_id, out_pc, out_num, out_taken, out_target, out_ghist
   );

   modport slave (
      output redir, redir_pc, redir_ghist,
      output upd_valid, upd_pc, upd_target, upd_taken, upd_kind, upd_ghist,
      output out_ready,
      input  out_valid, out_id, out_pc, out_num, out_taken, out_target, out_ghist
   );
endinterface

// File: rtl/pcgen_gshare.sv
// Frontend PC generator: gshare PHT, tagged BTB with branch kind, circular RAS.
// One fetch block per cycle toward the FTQ, predicted combinationally from current state.
module pcgen_gshare #(
   parameter logic [63:0] rst_pc = 64'h8000_0000,
   parameter int cbsz  = 64,
   parameter int fnum  = 4,
   parameter int phtsz = 512,
   parameter int btbsz = 64,
   parameter int tagw  = 8,
   parameter int hlen  = 8,
   parameter int rasd  = 8,
   parameter int idw   = 7
) (
   input logic clk,
   input logic rst_n,
   pcgen_gshare_if.master bus
);

   localparam int lcb  = $clog2(cbsz);
   localparam int lbtb = $clog2(btbsz);
   localparam int lpht = $clog2(phtsz);
   localparam int lras = $clog2(rasd);

   localparam logic [1:0] K_COND = 2'd0;
   localparam logic [1:0] K_JUMP = 2'd1;
   localparam logic [1:0] K_CALL = 2'd2;
   localparam logic [1:0] K_RET  = 2'd3;

   logic [63:0]     r_pc;
   logic [idw-1:0]  r_id;
   logic [hlen-1:0] r_ghist;

   logic            r_btb_v    [btbsz];
   logic [tagw-1:0] r_btb_tag  [btbsz];
   logic [63:0]     r_btb_tgt  [btbsz];
   logic [1:0]      r_btb_kind [btbsz];
   logic [1:0]      r_pht      [phtsz];

   logic [63:0]     r_ras [rasd];
   logic [lras-1:0] r_ras_ptr;
   logic [lras:0]   r_ras_cnt;

   logic [lras-1:0] w_ras_top_idx;
   logic [63:0]     w_ras_top;
   logic            w_ras_empty;
   logic [lcb:0]    w_room;
   logic [7:0]      w_room_slots;
   logic [7:0]      w_max_num;
   logic            w_found;
   logic [7:0]      w_k;
   logic [63:0]     w_tgt;
   logic            w_call;
   logic            w_ret;
   logic [63:0]     w_ret_addr;
   logic            w_has_cond;
   logic            w_cond_bit;
   logic [7:0]      w_num;
   logic            w_fire;
   logic [lbtb-1:0] w_upd_bi;
   logic [lpht-1:0] w_upd_pi;

   assign w_ras_top_idx = r_ras_ptr - lras'(1);
   assign w_ras_top     = r_ras[w_ras_top_idx];
   assign w_ras_empty   = (r_ras_cnt == '0);

   // a fetch block never crosses a cache block: bytes left to the boundary cap the slot count
   assign w_room       = (lcb+1)'(cbsz) - {1'b0, r_pc[lcb-1:0]};
   assign w_room_slots = 8'(w_room >> 1);
   assign w_max_num    = (w_room_slots < 8'(fnum)) ? w_room_slots : 8'(fnum);

   // scan slots in order; the first predicted-taken slot ends the block
   always_comb begin
      logic [63:0]     w_a;
      logic [lbtb-1:0] w_bi;
      logic [tagw-1:0] w_tg;
      logic [lpht-1:0] w_pi;
      logic            w_hit;
      logic            w_tk;
      w_found    = 1'b0;
      w_k        = '0;
      w_tgt      = '0;
      w_call     = 1'b0;
      w_ret      = 1'b0;
      w_ret_addr = '0;
      w_has_cond = 1'b0;
      w_cond_bit = 1'b0;
      w_a        = '0;
      w_bi       = '0;
      w_tg       = '0;
      w_pi       = '0;
      w_hit      = 1'b0;
      w_tk       = 1'b0;
      for (int i = 0; i < fnum; i++) begin
         w_a   = r_pc + 64'(2 * i);
         w_bi  = w_a[lbtb:1];
         w_tg  = w_a[lbtb+tagw:lbtb+1];
         w_pi  = w_a[lpht:1] ^ lpht'(r_ghist);
         w_hit = r_btb_v[w_bi] && (r_btb_tag[w_bi] == w_tg);
         w_tk  = 1'b0;
         if (w_hit) begin
            case (r_btb_kind[w_bi])
               K_COND:         w_tk = r_pht[w_pi][1];
               K_JUMP, K_CALL: w_tk = 1'b1;
               default:        w_tk = !w_ras_empty;
            endcase
         end
         if (!w_found && (8'(i) < w_max_num)) begin
            if (w_hit && (r_btb_kind[w_bi] == K_COND)) begin
               w_has_cond = 1'b1;
               w_cond_bit = w_tk;
            end
            if (w_tk) begin
               w_found    = 1'b1;
               w_k        = 8'(i);
               w_call     = (r_btb_kind[w_bi] == K_CALL);
               w_ret      = (r_btb_kind[w_bi] == K_RET);
               w_tgt      = w_ret ? w_ras_top : r_btb_tgt[w_bi];
               w_ret_addr = w_a + 64'd4;
            end
         end
      end
   end

   assign w_num  = w_found ? (w_k + 8'd1) : w_max_num;
   assign w_fire = bus.out_valid & bus.out_ready;

   assign bus.out_valid  = rst_n & ~bus.redir;
   assign bus.out_id     = r_id;
   assign bus.out_pc     = r_pc;
   assign bus.out_num    = w_num;
   assign bus.out_taken  = w_found;
   assign bus.out_target = w_tgt;
   assign bus.out_ghist  = r_ghist;

   // fetch state: redirect wins over a normal advance
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pc    <= rst_pc;
         r_id    <= '0;
         r_ghist <= '0;
      end else if (bus.redir) begin
         r_pc    <= bus.redir_pc;
         r_id    <= '0;
         r_ghist <= bus.redir_ghist;
      end else if (w_fire) begin
         r_id <= r_id + idw'(1);
         r_pc <= w_found ? w_tgt : (r_pc + 64'({w_num, 1'b0}));
         if (w_has_cond) r_ghist <= {r_ghist[hlen-2:0], w_cond_bit};
      end
   end

   // return stack: push on taken call, pop on taken ret; a full push drops the oldest entry
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ras_ptr <= '0;
         r_ras_cnt <= '0;
         for (int i = 0; i < rasd; i++) r_ras[i] <= '0;
      end else if (w_fire && w_call) begin
         r_ras[r_ras_ptr] <= w_ret_addr;
         r_ras_ptr        <= r_ras_ptr + lras'(1);
         if (r_ras_cnt != (lras+1)'(rasd)) r_ras_cnt <= r_ras_cnt + (lras+1)'(1);
      end else if (w_fire && w_ret) begin
         r_ras_ptr <= w_ras_top_idx;
         r_ras_cnt <= r_ras_cnt - (lras+1)'(1);
      end
   end

   assign w_upd_bi = bus.upd_pc[lbtb:1];
   assign w_upd_pi = bus.upd_pc[lpht:1] ^ lpht'(bus.upd_ghist);

   // direction training for resolved conditional branches
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < phtsz; i++) r_pht[i] <= 2'b01;
      end else if (bus.upd_valid && (bus.upd_kind == K_COND)) begin
         if (bus.upd_taken) begin
            if (r_pht[w_upd_pi] != 2'b11) r_pht[w_upd_pi] <= r_pht[w_upd_pi] + 2'b01;
         end else begin
            if (r_pht[w_upd_pi] != 2'b00) r_pht[w_upd_pi] <= r_pht[w_upd_pi] - 2'b01;
         end
      end
   end

   // target training: only taken branches allocate or refresh an entry
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < btbsz; i++) begin
            r_btb_v[i]    <= 1'b0;
            r_btb_tag[i]  <= '0;
            r_btb_tgt[i]  <= '0;
            r_btb_kind[i] <= '0;
         end
      end else if (bus.upd_valid && bus.upd_taken) begin
         r_btb_v[w_upd_bi]    <= 1'b1;
         r_btb_tag[w_upd_bi]  <= bus.upd_pc[lbtb+tagw:lbtb+1];
         r_btb_tgt[w_upd_bi]  <= bus.upd_target;
         r_btb_kind[w_upd_bi] <= bus.upd_kind;
      end
   end

endmodule

// File: tb/tb_pcgen_gshare.sv
// Directed bench for pcgen_gshare with hand-computed expectations.
module tb_pcgen_gshare;
   logic clk;
   logic rst_n;
   int   total;
   int   bad;

   pcgen_gshare_if #(.hlen(8), .idw(7)) bus ();

   pcgen_gshare u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic upd(input logic [63:0] pc, input logic [63:0] tgt, input logic tk,
                      input logic [1:0] kind, input logic [7:0] gh);
      bus.upd_valid  = 1'b1;
      bus.upd_pc     = pc;
      bus.upd_target = tgt;
      bus.upd_taken  = tk;
      bus.upd_kind   = kind;
      bus.upd_ghist  = gh;
   endtask

   task automatic upd_clear();
      bus.upd_valid = 1'b0;
      bus.upd_taken = 1'b0;
   endtask

   task automatic redir_set(input logic [63:0] pc, input logic [7:0] gh);
      bus.redir       = 1'b1;
      bus.redir_pc    = pc;
      bus.redir_ghist = gh;
   endtask

   initial begin
      total = 0;
      bad   = 0;
      rst_n = 1'b0;
      bus.redir = 1'b0; bus.redir_pc = '0; bus.redir_ghist = '0;
      bus.upd_valid = 1'b0; bus.upd_pc = '0; bus.upd_target = '0;
      bus.upd_taken = 1'b0; bus.upd_kind = '0; bus.upd_ghist = '0;
      bus.out_ready = 1'b0;

      // reset and sequential fetch
      repeat (2) @(posedge clk);
      #1;
      chk("rst_valid", bus.out_valid, 0);
      chk("rst_pc", bus.out_pc, 64'h8000_0000);
      rst_n = 1'b1;
      #1;
      chk("rel_valid", bus.out_valid, 1);
      chk("rel_num", bus.out_num, 4);
      chk("rel_id", bus.out_id, 0);
      chk("rel_taken", bus.out_taken, 0);
      chk("rel_ghist", bus.out_ghist, 0);
      bus.out_ready = 1'b1;
      tick();
      chk("seq1_pc", bus.out_pc, 64'h8000_0008);
      chk("seq1_id", bus.out_id, 1);
      tick();
      chk("seq2_pc", bus.out_pc, 64'h8000_0010);
      chk("seq2_id", bus.out_id, 2);
      chk("seq2_num", bus.out_num, 4);
      bus.out_ready = 1'b0;

      // block truncation at the cache-block boundary
      redir_set(64'h8000_003A, 8'h00);
      #1;
      chk("redir_valid", bus.out_valid, 0);
      tick();
      bus.redir = 1'b0;
      #1;
      chk("trunc_pc", bus.out_pc, 64'h8000_003A);
      chk("trunc_num", bus.out_num, 3);
      chk("trunc_id", bus.out_id, 0);
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
      #1;
      chk("trunc_next_pc", bus.out_pc, 64'h8000_0040);
      chk("trunc_next_num", bus.out_num, 4);

      // jump learned in BTB, redirect in the same cycle
      upd(64'h8000_0004, 64'h8000_1000, 1'b1, 2'd1, 8'h00);
      redir_set(64'h8000_0000, 8'h00);
      tick();
      upd_clear();
      bus.redir = 1'b0;
      #1;
      chk("jmp_num", bus.out_num, 3);
      chk("jmp_taken", bus.out_taken, 1);
      chk("jmp_target", bus.out_target, 64'h8000_1000);
      chk("jmp_id", bus.out_id, 0);
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
      #1;
      chk("jmp_next_pc", bus.out_pc, 64'h8000_1000);
      chk("jmp_next_id", bus.out_id, 1);
      chk("jmp_next_taken", bus.out_taken, 0);

      // conditional branch at 0x80002002: PHT index 1 with ghist 0
      upd(64'h8000_2002, 64'h8000_3000, 1'b1, 2'd0, 8'h00);
      redir_set(64'h8000_2000, 8'h00);
      tick();
      bus.redir = 1'b0;
      tick();
      upd_clear();
      #1;
      chk("cond_tt_taken", bus.out_taken, 1);
      chk("cond_tt_num", bus.out_num, 2);
      chk("cond_tt_target", bus.out_target, 64'h8000_3000);
      chk("cond_tt_ghist", bus.out_ghist, 8'h00);
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
      #1;
      chk("cond_fire_pc", bus.out_pc, 64'h8000_3000);
      chk("cond_fire_ghist", bus.out_ghist, 8'h01);
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
      #1;
      chk("nocond_pc", bus.out_pc, 64'h8000_3008);
      chk("nocond_ghist", bus.out_ghist, 8'h01);
      // ghist 1 moves the lookup to PHT index 0, still at 01
      redir_set(64'h8000_2000, 8'h01);
      tick();
      bus.redir = 1'b0;
      #1;
      chk("alias_taken", bus.out_taken, 0);
      chk("alias_num", bus.out_num, 4);
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
      #1;
      chk("nt_shift_pc", bus.out_pc, 64'h8000_2008);
      chk("nt_shift_ghist", bus.out_ghist, 8'h02);
      upd(64'h8000_2002, 64'h0, 1'b0, 2'd0, 8'h00);
      redir_set(64'h8000_2000, 8'h00);
      tick();
      upd_clear();
      bus.redir = 1'b0;
      #1;
      chk("cond_n1_taken", bus.out_taken, 1);
      upd(64'h8000_2002, 64'h0, 1'b0, 2'd0, 8'h00);
      tick();
      upd_clear();
      #1;
      chk("cond_n2_taken", bus.out_taken, 0);
      chk("cond_n2_target", bus.out_target, 64'h0);
      chk("cond_n2_num", bus.out_num, 4);

      // call / ret
      upd(64'h100, 64'h800, 1'b1, 2'd2, 8'h00);
      tick();
      upd(64'h810, 64'h0, 1'b1, 2'd3, 8'h00);
      tick();
      upd_clear();
      redir_set(64'h100, 8'h00);
      tick();
      bus.redir = 1'b0;
      #1;
      chk("call_taken", bus.out_taken, 1);
      chk("call_num", bus.out_num, 1);
      chk("call_target", bus.out_target, 64'h800);
      bus.out_ready = 1'b1;
      tick();
      chk("call_next_pc", bus.out_pc, 64'h800);
      tick();
      chk("callee_pc2", bus.out_pc, 64'h808);
      tick();
      chk("ret_pc", bus.out_pc, 64'h810);
      chk("ret_taken", bus.out_taken, 1);
      chk("ret_target", bus.out_target, 64'h104);
      tick();
      bus.out_ready = 1'b0;
      #1;
      chk("ret_next_pc", bus.out_pc, 64'h104);
      redir_set(64'h810, 8'h00);
      tick();
      bus.redir = 1'b0;
      #1;
      chk("ret_empty_taken", bus.out_taken, 0);
      chk("ret_empty_num", bus.out_num, 4);

      // rasd+1 nested calls: chain of calls at 0x1000 + 4j
      for (int j = 0; j < 9; j++) begin
         upd(64'h1000 + 64'(4 * j), (j < 8) ? (64'h1004 + 64'(4 * j)) : 64'h3000,
             1'b1, 2'd2, 8'h00);
         tick();
      end
      upd(64'h5002, 64'h0, 1'b1, 2'd3, 8'h00);
      tick();
      upd_clear();
      redir_set(64'h1000, 8'h00);
      tick();
      bus.redir = 1'b0;
      bus.out_ready = 1'b1;
      #1;
      for (int j = 0; j < 9; j++) begin
         chk("chain_pc", bus.out_pc, 64'h1000 + 64'(4 * j));
         chk("chain_target", bus.out_target,
             (j < 8) ? (64'h1004 + 64'(4 * j)) : 64'h3000);
         tick();
      end
      bus.out_ready = 1'b0;
      #1;
      chk("chain_end_pc", bus.out_pc, 64'h3000);
      for (int j = 0; j < 8; j++) begin
         redir_set(64'h5000, 8'h00);
         tick();
         bus.redir = 1'b0;
         bus.out_ready = 1'b1;
         #1;
         chk("pop_taken", bus.out_taken, 1);
         chk("pop_target", bus.out_target, 64'h1024 - 64'(4 * j));
         tick();
         bus.out_ready = 1'b0;
      end
      redir_set(64'h5000, 8'h00);
      tick();
      bus.redir = 1'b0;
      #1;
      chk("pop_empty_taken", bus.out_taken, 0);

      // asynchronous reset mid-stream
      upd(64'h8000_0004, 64'h8000_1000, 1'b1, 2'd1, 8'h00);
      redir_set(64'h8000_0000, 8'h00);
      tick();
      upd_clear();
      bus.redir = 1'b0;
      #1;
      chk("prerst_taken", bus.out_taken, 1);
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
      #1;
      chk("prerst_pc", bus.out_pc, 64'h8000_1000);
      rst_n = 1'b0;
      #1;
      chk("arst_valid", bus.out_valid, 0);
      chk("arst_pc", bus.out_pc, 64'h8000_0000);
      chk("arst_id", bus.out_id, 0);
      tick();
      rst_n = 1'b1;
      #1;
      chk("postrst_valid", bus.out_valid, 1);
      chk("postrst_pc", bus.out_pc, 64'h8000_0000);
      chk("postrst_id", bus.out_id, 0);
      chk("postrst_taken", bus.out_taken, 0);
      chk("postrst_num", bus.out_num, 4);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/pcgen_gshare.md
Name: pcgen_gshare

Overview:
- Next-generation frontend PC generator and branch predictor. Each cycle it presents one fetch block to the fetch target queue.
- Prediction uses a gshare PHT of 2-bit saturating counters, a tagged BTB that records branch kind, and a circular return address stack (RAS).
- Supplies the global-history snapshot needed for backend recovery. The backend feeds resolved branches and redirects back in.

Parameters:
- rst_pc, 64'h8000_0000, PC loaded on reset.
- cbsz, 64, cache block size in bytes (power of 2); a fetch block never crosses it.
- fnum, 4, max 2-byte slots per fetch block.
- phtsz, 512, PHT entries (power of 2).
- btbsz, 64, BTB entries (power of 2).
- tagw, 8, BTB tag width.
- hlen, 8, global history length in bits; must satisfy hlen <= log2(phtsz).
- rasd, 8, RAS depth (power of 2).
- idw, 7, FTQ identifier width.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- redir  in  1  backend redirect
- redir_pc  in  64  corrected PC
- redir_ghist  in  hlen  corrected global history
- upd_valid  in  1  resolved-branch update
- upd_pc  in  64  branch PC
- upd_target  in  64  resolved target
- upd_taken  in  1  resolved direction
- upd_kind  in  2  0 cond, 1 jump, 2 call, 3 ret
- upd_ghist  in  hlen  history used at prediction time
- out_ready  in  1  FTQ can accept
- out_valid  out  1  block valid
- out_id  out  idw  block id
- out_pc  out  64  block start PC
- out_num  out  8  slots in block (1..fnum)
- out_taken  out  1  block ends in predicted-taken branch
- out_target  out  64  predicted target (0 if not taken)
- out_ghist  out  hlen  history snapshot for this block

Behaviour:
- Reset (rst_n low, async):
  - pc_r=rst_pc, id_r=0, ghist=0.
  - All BTB valid bits cleared; all PHT counters set to 2'b01; RAS pointer and count set to 0.
  - out_valid=0 while in reset.
- out_valid=1 every cycle except during reset and in any cycle with redir=1.
- Handshake: fire = out_valid & out_ready. State (pc_r, id_r, ghist, RAS) advances only on fire or redir.
- Output is combinational from current state; zero-cycle prediction latency.
- Slot i address a_i = pc_r + 2i, for i < fnum.
- Block truncation: if pc_r is not cbsz-aligned and fnum slots would cross the block boundary, out_num = (cbsz - pc_r mod cbsz)/2, and slots beyond it are ignored for prediction.
- BTB lookup:
  - index = a_i[log2(btbsz):1]
  - tag = a_i[log2(btbsz)+tagw:log2(btbsz)+1]
  - hit = valid & tag match.
- PHT index = a_i[log2(phtsz):1] XOR zero-extended ghist.
- Slot taken if BTB hit and any of:
  - kind cond with counter[1]=1;
  - kind jump or call;
  - kind ret with RAS non-empty.
- The first taken slot k ends the block: out_num=k+1, out_taken=1.
  - out_target = BTB target, or RAS top for ret.
- With no taken slot: out_taken=0, out_target=0, out_num = fnum or the truncated value.
- On fire:
  - id_r <= id_r+1, wrapping mod 2^idw.
  - pc_r <= out_taken ? out_target : pc_r + 2*out_num.
  - ghist <= {ghist[hlen-2:0], b} if the block contains a BTB-hit cond slot within out_num, where b = taken bit of the last such slot; otherwise ghist is unchanged.
  - Taken call: push a_k+4.
  - Taken ret: pop.
- RAS rules:
  - Push when full overwrites the oldest entry; count stays at rasd.
  - Pop when empty cannot occur, since a ret is never predicted taken with an empty RAS.
- redir (has priority over fire):
  - pc_r <= redir_pc, id_r <= 0, ghist <= redir_ghist.
  - RAS is not repaired.
- Update (independent of redir; both may act in the same cycle):
  - PHT: if upd_kind==cond, the PHT entry at upd_pc[log2(phtsz):1] XOR upd_ghist saturating-increments when taken and saturating-decrements when not taken.
  - BTB: if upd_taken, the BTB entry at upd_pc is written with valid=1, tag, upd_target and upd_kind.
  - A not-taken branch never allocates a BTB entry.
- Same-cycle update and lookup of one entry: the lookup sees the old value; the write is visible next cycle.

Test Plan:
- Reset release with rst_pc=0x8000_0000, no BTB hits -> out_pc sequence 0x80000000, 0x80000008, 0x80000010; out_num=4; out_id=0,1,2.
- Start PC 0x8000003A with cbsz=64 -> out_num=3, next out_pc=0x80000040.
- Update jump at 0x80000004 targeting 0x80001000, then redir to 0x80000000 -> out_num=3, out_taken=1, next out_pc=0x80001000, out_id restarts at 0.
- Cond branch updated taken twice from reset (01->10->11) -> predicted taken; then one not-taken update -> still taken; a second not-taken update -> not taken. Also check ghist shifts as expected.
- Call at 0x100 to 0x800, ret at 0x810 -> ret block out_target=0x104. After rasd+1 nested calls, the RAS keeps the newest rasd return addresses.
- Assert rst_n mid-stream with out_ready=0 -> outputs drop asynchronously; after release, out_pc=rst_pc, out_id=0 and no BTB hits.
